// File: rtl/sram_like_bridge.sv
// sram_like_bridge: CPU SRAM-style port to SRAM-like bus handshake, one transfer in flight.
// Optional one-entry read buffer is enabled by defining SRAM_LIKE_RBUF_EN.
module sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W/8,
  parameter int SIZE_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              req,
  output logic              wr,
  output logic [SIZE_W-1:0] size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              addr_ok,
  input  logic              data_ok
);
  localparam int LG = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DISCARD, DONE} state_t;
  state_t state, state_nxt;

  logic              flush_seen;
  logic              is_wr;
  logic              take;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [SIZE_W-1:0] wsize;
  logic [SIZE_W-1:0] lsize;
  logic [LG-1:0]     woff;
  logic [ADDR_W-1:0] laddr;
  logic              unused_addr_lsb;

  assign is_wr = |cpu_wen;
  assign unused_addr_lsb = ^cpu_addr[LG-1:0];

  // Match wen against every naturally aligned contiguous run; anything else is a full-width write.
  always_comb begin
    wsize = SIZE_W'(LG);
    woff  = '0;
    for (int s = 0; s <= LG; s++) begin
      for (int o = 0; o < STRB_W; o += (1 << s)) begin
        if (cpu_wen == STRB_W'(((1 << (1 << s)) - 1) << o)) begin
          wsize = SIZE_W'(s);
          woff  = LG'(o);
        end
      end
    end
  end

  assign lsize = is_wr ? wsize : SIZE_W'(LG);
  assign laddr = {cpu_addr[ADDR_W-1:LG], (is_wr ? woff : LG'(0))};
  assign take  = (state == IDLE) && cpu_en && !flush;

`ifdef SRAM_LIKE_RBUF_EN
  logic              rb_valid;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;

  assign hit      = rb_valid && !is_wr && (rb_addr == laddr);
  assign hit_data = rb_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rb_valid <= 1'b0;
      rb_addr  <= '0;
      rb_data  <= '0;
    end else if (flush) begin
      rb_valid <= 1'b0;
    end else if (state == WAIT && data_ok && !wr) begin
      rb_valid <= 1'b1;
      rb_addr  <= addr;
      rb_data  <= rdata;
    end else if (state == IDLE && cpu_en && is_wr &&
                 cpu_addr[ADDR_W-1:LG] == rb_addr[ADDR_W-1:LG]) begin
      rb_valid <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = (state == REQ);
    cpu_stall = 1'b0;
    if (resetn)
      cpu_stall = (cpu_en && state != DONE && !flush) ||
                  state == REQ || state == WAIT || state == DISCARD;
    case (state)
      IDLE:    if (take) state_nxt = hit ? DONE : REQ;
      // The request cannot be withdrawn once raised; a flush only redirects its response.
      REQ:     if (addr_ok) state_nxt = (flush || flush_seen) ? DISCARD : WAIT;
      WAIT: begin
        if (data_ok)    state_nxt = flush ? IDLE : DONE;
        else if (flush) state_nxt = DISCARD;
      end
      DISCARD: if (data_ok) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      flush_seen <= 1'b0;
      wr         <= 1'b0;
      size       <= '0;
      addr       <= '0;
      wdata      <= '0;
      cpu_rdata  <= '0;
    end else begin
      flush_seen <= (state == REQ) && !addr_ok && (flush || flush_seen);
      if (take && !hit) begin
        wr    <= is_wr;
        size  <= lsize;
        addr  <= laddr;
        wdata <= cpu_wdata;
      end
      if (take && hit)
        cpu_rdata <= hit_data;
      else if (state == WAIT && data_ok && !flush && !wr)
        cpu_rdata <= rdata;
    end
  end
endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: directed scenarios with an rdata scoreboard.
module tb_sram_like_bridge;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        cpu_en = 1'b0;
  logic [3:0]  cpu_wen = '0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata = '0;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = '0;

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .STRB_W(4), .SIZE_W(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .rdata(rdata),
    .addr_ok(addr_ok), .data_ok(data_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic pop_check(input string name);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL %s scoreboard empty got=%h", name, cpu_rdata);
    end else begin
      e = exp_q.pop_front();
      if (cpu_rdata !== e) begin failures++; $display("FAIL %s cpu_rdata got=%h exp=%h", name, cpu_rdata, e); end
      last_rd = e;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; cpu_en = 1'b1; cpu_addr = 32'h1234;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
    checks++; if ({req, wr, size} !== 4'b0) begin failures++; $display("FAIL rst_ctl got=%b exp=0", {req, wr, size}); end
    checks++; if ({addr, wdata, cpu_rdata} !== 96'b0) begin failures++; $display("FAIL rst_data got=%h exp=0", {addr, wdata, cpu_rdata}); end
    @(negedge clk); resetn = 1'b1; cpu_en = 1'b0; last_rd = '0;
  endtask

  task automatic test_read;
    @(negedge clk); cpu_en = 1'b1; cpu_wen = 4'b0; cpu_addr = 32'hBFC00000; #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rd_c0_req got=%b exp=0", req); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rd_c0_stall got=%b exp=1", cpu_stall); end
    exp_q.push_back(32'h3C080001);
    @(negedge clk); addr_ok = 1'b1; #1;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL rd_c1_req got=%b exp=1", req); end
    checks++; if ({wr, size, addr} !== {1'b0, 2'd2, 32'hBFC00000}) begin failures++; $display("FAIL rd_c1_bus got=%h exp=%h", {wr, size, addr}, {1'b0, 2'd2, 32'hBFC00000}); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rd_c1_stall got=%b exp=1", cpu_stall); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3C080001; #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rd_c2_req got=%b exp=0", req); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rd_c2_stall got=%b exp=1", cpu_stall); end
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rd_c3_stall got=%b exp=0", cpu_stall); end
    pop_check("rd_c3");
    @(negedge clk); cpu_en = 1'b0; #1;
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL rd_c4_req got=%b exp=0", req); end
  endtask

  task automatic test_write_size;
    logic [31:0] ta[4] = '{32'h80001003, 32'h80001000, 32'h80001007, 32'h80001002};
    logic [3:0]  tw[4] = '{4'b1000, 4'b1100, 4'b0101, 4'b0011};
    logic [31:0] td[4] = '{32'hAB000000, 32'hCDEF0000, 32'h11223344, 32'h00005566};
    logic [1:0]  es[4] = '{2'd0, 2'd1, 2'd2, 2'd1};
    logic [31:0] ea[4] = '{32'h80001003, 32'h80001002, 32'h80001004, 32'h80001000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cpu_en = 1'b1; cpu_wen = tw[i]; cpu_addr = ta[i]; cpu_wdata = td[i]; #1;
      exp_q.push_back(last_rd);
      @(negedge clk); addr_ok = 1'b1; #1;
      checks++; if ({req, wr} !== 2'b11) begin failures++; $display("FAIL wr%0d_req_wr got=%b exp=11", i, {req, wr}); end
      checks++; if (size !== es[i]) begin failures++; $display("FAIL wr%0d_size got=%0d exp=%0d", i, size, es[i]); end
      checks++; if (addr !== ea[i]) begin failures++; $display("FAIL wr%0d_addr got=%h exp=%h", i, addr, ea[i]); end
      checks++; if (wdata !== td[i]) begin failures++; $display("FAIL wr%0d_wdata got=%h exp=%h", i, wdata, td[i]); end
      @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hFFFFFFFF;
      @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL wr%0d_done_stall got=%b exp=0", i, cpu_stall); end
      pop_check("wr_done");
      @(negedge clk); cpu_en = 1'b0; cpu_wen = '0;
    end
  endtask

  task automatic test_addr_ok_delay;
    @(negedge clk); cpu_en = 1'b1; cpu_wen = '0; cpu_addr = 32'h10000010; #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      addr_ok = (i == 5); data_ok = (i == 2); rdata = (i == 2) ? 32'h99999999 : 32'h0;
      cpu_addr = 32'hFFFFFFF0; #1;
      checks++; if ({req, cpu_stall} !== 2'b11) begin failures++; $display("FAIL dly%0d_req_stall got=%b exp=11", i, {req, cpu_stall}); end
      checks++; if ({size, addr} !== {2'd2, 32'h10000010}) begin failures++; $display("FAIL dly%0d_addr got=%h exp=%h", i, {size, addr}, {2'd2, 32'h10000010}); end
    end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h12345678; #1;
    exp_q.push_back(32'h12345678);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL dly_wait_req got=%b exp=0", req); end
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL dly_done_stall got=%b exp=0", cpu_stall); end
    pop_check("dly_done");
    @(negedge clk); cpu_en = 1'b0;
  endtask

  task automatic test_flush_wait;
    @(negedge clk); cpu_en = 1'b1; cpu_addr = 32'h00000020;
    @(negedge clk); addr_ok = 1'b1;
    @(negedge clk); addr_ok = 1'b0; flush = 1'b1; #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL fw_wait_stall got=%b exp=1", cpu_stall); end
    @(negedge clk); flush = 1'b0; cpu_en = 1'b0; #1;
    checks++; if ({req, cpu_stall} !== 2'b01) begin failures++; $display("FAIL fw_disc1 got=%b exp=01", {req, cpu_stall}); end
    @(negedge clk); data_ok = 1'b1; rdata = 32'hDEADBEEF; #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL fw_disc2_stall got=%b exp=1", cpu_stall); end
    @(negedge clk); data_ok = 1'b0; rdata = '0; cpu_en = 1'b1; cpu_addr = 32'h00000024; #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL fw_idle_stall got=%b exp=1", cpu_stall); end
    checks++; if (cpu_rdata !== last_rd) begin failures++; $display("FAIL fw_rdata_kept got=%h exp=%h", cpu_rdata, last_rd); end
    exp_q.push_back(32'h5555AAAA);
    @(negedge clk); addr_ok = 1'b1; #1;
    checks++; if ({req, addr} !== {1'b1, 32'h00000024}) begin failures++; $display("FAIL fw_b2b_req got=%h exp=%h", {req, addr}, {1'b1, 32'h00000024}); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h5555AAAA;
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL fw_b2b_done got=%b exp=0", cpu_stall); end
    pop_check("fw_b2b");
    @(negedge clk); cpu_en = 1'b0;
  endtask

  task automatic test_flush_req;
    @(negedge clk); cpu_en = 1'b1; cpu_addr = 32'h00000030;
    @(negedge clk); flush = 1'b1; #1;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL fr_req1 got=%b exp=1", req); end
    @(negedge clk); flush = 1'b0; cpu_en = 1'b0; addr_ok = 1'b1; #1;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL fr_req2 got=%b exp=1", req); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h77777777; #1;
    checks++; if ({req, cpu_stall} !== 2'b01) begin failures++; $display("FAIL fr_disc got=%b exp=01", {req, cpu_stall}); end
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    checks++; if (cpu_rdata !== last_rd) begin failures++; $display("FAIL fr_rdata_kept got=%h exp=%h", cpu_rdata, last_rd); end
    @(negedge clk); #1;
    checks++; if ({req, cpu_stall} !== 2'b00) begin failures++; $display("FAIL fr_idle got=%b exp=00", {req, cpu_stall}); end
  endtask

  task automatic test_flush_same;
    @(negedge clk); cpu_en = 1'b1; cpu_addr = 32'h00000040;
    @(negedge clk); addr_ok = 1'b1;
    @(negedge clk); addr_ok = 1'b0; flush = 1'b1; data_ok = 1'b1; rdata = 32'h99990000;
    @(negedge clk); flush = 1'b0; data_ok = 1'b0; rdata = '0; cpu_addr = 32'h00000044; #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL fs_idle_stall got=%b exp=1", cpu_stall); end
    checks++; if (cpu_rdata !== last_rd) begin failures++; $display("FAIL fs_rdata_kept got=%h exp=%h", cpu_rdata, last_rd); end
    exp_q.push_back(32'h44444444);
    @(negedge clk); addr_ok = 1'b1; #1;
    checks++; if ({req, addr} !== {1'b1, 32'h00000044}) begin failures++; $display("FAIL fs_new_req got=%h exp=%h", {req, addr}, {1'b1, 32'h00000044}); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h44444444;
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    pop_check("fs_new");
    @(negedge clk); cpu_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); cpu_en = 1'b1; cpu_addr = 32'h00000050;
    @(negedge clk); addr_ok = 1'b1; cpu_wen = '0;
    @(negedge clk); addr_ok = 1'b0; resetn = 1'b0;
    @(negedge clk); #1;
    checks++; if ({req, wr, size, cpu_stall} !== 5'b0) begin failures++; $display("FAIL rm_ctl got=%b exp=0", {req, wr, size, cpu_stall}); end
    checks++; if ({addr, wdata, cpu_rdata} !== 96'b0) begin failures++; $display("FAIL rm_data got=%h exp=0", {addr, wdata, cpu_rdata}); end
    last_rd = '0;
    @(negedge clk); resetn = 1'b1; cpu_en = 1'b0; data_ok = 1'b1; rdata = 32'h5A5A5A5A;
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    checks++; if ({req, cpu_stall} !== 2'b00) begin failures++; $display("FAIL rm_stray_ctl got=%b exp=00", {req, cpu_stall}); end
    checks++; if (cpu_rdata !== 32'h0) begin failures++; $display("FAIL rm_stray_rdata got=%h exp=0", cpu_rdata); end
  endtask

  task automatic test_repeat_read;
    @(negedge clk); cpu_en = 1'b1; cpu_wen = '0; cpu_addr = 32'h00000100;
    exp_q.push_back(32'hCAFE0100);
    @(negedge clk); addr_ok = 1'b1; #1;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL rr_first_req got=%b exp=1", req); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE0100;
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    pop_check("rr_first");
    @(negedge clk); #1;
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL rr_second_c0 got=%b exp=1", cpu_stall); end
    exp_q.push_back(32'hCAFE0100);
`ifdef SRAM_LIKE_RBUF_EN
    @(negedge clk); #1;
    checks++; if ({req, cpu_stall} !== 2'b00) begin failures++; $display("FAIL rr_hit got=%b exp=00", {req, cpu_stall}); end
    pop_check("rr_hit");
`else
    @(negedge clk); addr_ok = 1'b1; #1;
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL rr_second_req got=%b exp=1", req); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hCAFE0100;
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    pop_check("rr_second");
`endif
    @(negedge clk); cpu_wen = 4'b1111; cpu_wdata = 32'h01020304;
    exp_q.push_back(last_rd);
    @(negedge clk); addr_ok = 1'b1; #1;
    checks++; if ({req, wr, addr} !== {2'b11, 32'h00000100}) begin failures++; $display("FAIL rr_wr got=%h exp=%h", {req, wr, addr}, {2'b11, 32'h00000100}); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1;
    @(negedge clk); data_ok = 1'b0; #1;
    pop_check("rr_wr");
    @(negedge clk); cpu_wen = '0;
    exp_q.push_back(32'h0BADF00D);
    @(negedge clk); addr_ok = 1'b1; #1;
    checks++; if ({req, wr} !== 2'b10) begin failures++; $display("FAIL rr_after_wr_req got=%b exp=10", {req, wr}); end
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0BADF00D;
    @(negedge clk); data_ok = 1'b0; rdata = '0; #1;
    pop_check("rr_after_wr");
    @(negedge clk); cpu_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_size();
    test_addr_ok_delay();
    test_flush_wait();
    test_flush_req();
    test_flush_same();
    test_reset_mid();
    test_repeat_read();
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_like_bridge.md
Name: sram_like_bridge

Overview:
Parametrised single-channel bridge from the CPU's SRAM-style port (en/wen/addr/wdata) to the SRAM-like bus handshake (req/wr/size/addr/wdata, addr_ok/data_ok).
- Stalls the pipeline while a transfer is in flight.
- Converts byte-lane write enables into size/address.
- Makes flush safe mid-transfer by discarding orphaned responses.
- One instance serves instruction fetch, a second serves data; both sit between the CPU core and the SRAM-like-to-AXI converter.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; legal values 32 or 64
STRB_W, DATA_W/8, byte-enable width
SIZE_W, 2, bus size width; encodes log2(bytes), so 64-bit mode uses size 3

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
flush  in  1  pipeline flush; cancels delivery of the current/pending transfer
cpu_en  in  1  CPU access request
cpu_wen  in  STRB_W  byte write enables; all-zero means read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data, valid in DONE cycle
cpu_stall  out  1  hold pipeline
req  out  1  bus request
wr  out  1  1 = write
size  out  SIZE_W  log2 bytes
addr  out  ADDR_W  bus address
wdata  out  DATA_W  bus write data
rdata  in  DATA_W  bus read data
addr_ok  in  1  address accepted
data_ok  in  1  data returned / write complete

Behaviour:
- Reset (resetn=0 at clk edge):
  - state=IDLE; req=0, wr=0, size=0, addr=0, wdata=0, cpu_rdata=0.
  - cpu_stall=0 combinationally while resetn=0.
- States: IDLE, REQ, WAIT, DISCARD, DONE.
- IDLE:
  - cpu_en=1 and flush=0 → latch addr, wr=|cpu_wen, size, wdata; next cycle req=1, state REQ.
  - cpu_en=1 with flush=1 → no request.
- REQ:
  - req held with stable addr/wr/size/wdata until addr_ok=1.
  - On addr_ok: req=0 next cycle; state WAIT, or DISCARD if flush seen in REQ or on the addr_ok cycle.
  - data_ok is ignored in REQ.
- WAIT:
  - data_ok=1 → cpu_rdata<=rdata on reads (unchanged on writes); state DONE.
  - flush=1 with no data_ok → DISCARD.
  - flush and data_ok in the same cycle → IDLE; cpu_rdata unchanged.
- DISCARD: on data_ok → IDLE; rdata is dropped and cpu_rdata is unchanged.
- DONE:
  - One cycle with cpu_stall=0; the CPU consumes the result. Next cycle → IDLE.
  - A new cpu_en is taken only from IDLE, so issue rate is one access per 4 cycles minimum.
- cpu_stall = cpu_en & ~(state==DONE) & ~flush, plus 1 in REQ/WAIT/DISCARD regardless of cpu_en.
- Minimum read latency: en at cycle 0, req at cycle 1 (addr_ok same cycle), data_ok at cycle 2, DONE at cycle 3.
- Write size/address mapping: the legal wen patterns are naturally aligned contiguous runs of 1, 2, 4 or 8 bytes.
  - size = log2 of the run length.
  - addr low bits = byte offset of the lowest set lane.
  - wdata passes through unshifted (lane positions kept).
- Illegal wen pattern (e.g. 0101): full-width write, size=log2(STRB_W), addr low bits zeroed.
- Reads: size=log2(STRB_W), addr aligned to DATA_W.
- Only one outstanding transfer at a time; at most one data_ok per accepted request.
- Reset mid-transfer clears state immediately. The external bus must be reset together with this block.

Optional Feature:
SRAM_LIKE_RBUF_EN
- Defined: one-entry read buffer {valid, addr, data}.
  - Filled on each completed read.
  - An IDLE read with cpu_addr equal to the buffered addr and valid=1 goes straight to DONE next cycle with the buffered data and no bus request; cpu_stall is high for 1 cycle.
  - valid is cleared by reset, by flush, and by any write whose aligned addr matches the buffered addr.
- Undefined: no buffer; every access goes to the bus.

Test Plan:
- Read 0xBFC00000, addr_ok at cycle 1, data_ok with rdata=0x3C080001 at cycle 2 → req high cycle 1 only, cpu_rdata=0x3C080001 at cycle 3, cpu_stall low at cycle 3 only.
- Write 0x80001003, wen=1000, wdata=0xAB000000 → wr=1, size=0, addr=0x80001003, wdata=0xAB000000; wen=1100 at 0x80001000 → size=1, addr=0x80001002.
- addr_ok delayed 5 cycles → req and addr stay stable for all 6 cycles; cpu_stall held high throughout.
- flush in WAIT, data_ok 2 cycles later with rdata=0xDEADBEEF → state DISCARD then IDLE; cpu_rdata keeps its prior value; no DONE cycle.
- resetn low during WAIT → all outputs 0 next edge; a stray data_ok afterwards has no effect.
- With SRAM_LIKE_RBUF_EN: read 0x100 twice → one bus req; second read returns the same data in 2 cycles. Then write 0x100 and read 0x100 → bus req issued.
